mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; all ports are listed below.
- CLK  in  1  system clock, all state on rising edge
- RST  in  1  synchronous active-high reset
- dREN_EX_MEM  in  1  load in EX/MEM register
- dWEN_EX_MEM  in  1  store in EX/MEM register
- datomic_EX_MEM  in  1  LL (with dREN) / SC (with dWEN)
- dmemaddr_EX_MEM  in  32  data address
- dmemstore_EX_MEM  in  32  store data
- halt_EX_MEM  in  1  halt reached MEM
- dhit  in  1  cache completes current request
- dmemload  in  32  cache read data
- snoop_inv  in  1  coherence invalidate this cycle
- snoop_addr  in  32  invalidated address
- dREN  out  1  read request to cache
- dWEN  out  1  write request to cache
- daddr  out  32  request address
- dstore  out  32  request write data
- dload_MEM  out  32  captured load data to MEM/WB
- sc_result  out  32  SC outcome, 1 = success, 0 = fail
- mem_stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- mem_done  out  1  access complete; MEM/WB may latch

Function
REQ-002 The FSM SHALL have states IDLE, REQ, DONE.
REQ-003 IDLE: if (dREN_EX_MEM|dWEN_EX_MEM) & !halt_EX_MEM, go to REQ with mem_stall=1 that cycle; otherwise stay in IDLE with mem_stall=0.
REQ-004 REQ: dREN/dWEN SHALL mirror the EX/MEM flags, with daddr=dmemaddr_EX_MEM and dstore=dmemstore_EX_MEM; mem_stall=1; the state is held until dhit.
REQ-005 REQ with dhit: dload_MEM SHALL latch dmemload (loads only) and the state goes to DONE.
REQ-006 DONE: mem_done=1 and mem_stall=0 for exactly one cycle; no request is driven; the next state is always IDLE.
REQ-007 Minimum latency SHALL be 3 cycles (IDLE, REQ with dhit, DONE); each extra cycle without dhit adds one.
REQ-008 Outside REQ, dREN=dWEN=0.
REQ-009 Link register: link_valid plus link_addr[31:2]; address compares SHALL use bits [31:2] only.
REQ-010 LL completion (REQ, dREN & datomic & dhit) SHALL set link_valid and link_addr.
REQ-011 SC in IDLE with link_valid and an address match SHALL proceed as a normal store, set sc_result=1 in DONE, and clear link_valid at dhit.
REQ-012 SC in IDLE without a link match SHALL go directly to DONE with no cache request and sc_result=0.
REQ-013 An ordinary store completion to link_addr SHALL clear link_valid.
REQ-014 snoop_inv with snoop_addr[31:2]==link_addr SHALL clear link_valid.
REQ-015 If a snoop clear and an LL set fall on the same edge with matching addresses, the clear SHALL win.
REQ-016 sc_result SHALL hold its value until the next SC completes.

Reset
REQ-017 On RST the block SHALL enter IDLE with link_valid=0, link_addr=0, dload_MEM=0, sc_result=0, and all request, stall and done outputs at 0.
REQ-018 RST during REQ SHALL drop requests at the same edge; the pending access is abandoned.

Configuration
REQ-019 Macro MEM_STAGE_LLSC_EN SHALL control LL/SC support:
- Defined: REQ-009..016 apply.
- Undefined: datomic_EX_MEM is ignored; LL behaves as a load and SC as a plain store; sc_result is tied to 0; no link register exists.

Structure
REQ-020 The mem_stage_state_t enum (IDLE/REQ/DONE) SHALL live in data_path_muxs_pkg; word_t comes from cpu_types_pkg.
REQ-021 The link register SHALL be the sub-module mem_link_reg (set, clear, snoop-compare, valid, addr).

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- LW 0x100, dhit after 2 wait cycles, dmemload=0xDEADBEEF -> stall for 4 cycles, then mem_done with dload_MEM=0xDEADBEEF.
- SW 0x200 data 0x12345678, immediate dhit -> dWEN=1 for one cycle, daddr=0x200, dstore=0x12345678.
- LL 0x300, then SC 0x300 -> SC issues dWEN; sc_result=1; link_valid=0 afterwards.
- LL 0x300, snoop_inv 0x302, then SC 0x300 -> no dWEN; sc_result=0 in DONE.
- RST asserted in REQ -> next cycle IDLE, dREN=0, mem_stall=0; a build without MEM_STAGE_LLSC_EN sees SC act as a store with sc_result=0.
- halt_EX_MEM=1 with dREN=1 -> no request; block remains IDLE.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide scalar types.
package cpu_types_pkg;
  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/data_path_muxs_pkg.sv
// Datapath control types: MEM stage state encoding and word-address compare helper.
package data_path_muxs_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_stage_state_t;

  // Link compares ignore the byte offset within a word.
  function automatic logic word_match(input logic [29:0] a, input logic [29:0] b);
    return a == b;
  endfunction
endpackage

// File: rtl/mem_link_reg.sv
// LL/SC link register: holds a word address and a valid bit, cleared by stores or snoops.
module mem_link_reg
  import data_path_muxs_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        set,
  input  logic [29:0] set_addr,
  input  logic        clr,
  input  logic        snoop_inv,
  input  logic [29:0] snoop_addr,
  output logic        valid,
  output logic [29:0] addr
);
  logic snoop_old;
  logic snoop_new;

  assign snoop_old = snoop_inv & word_match(snoop_addr, addr);
  assign snoop_new = snoop_inv & word_match(snoop_addr, set_addr);

  // A snoop on the address being linked this same edge beats the LL set.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      addr  <= '0;
    end else if (set) begin
      addr  <= set_addr;
      valid <= ~snoop_new;
    end else if (clr | snoop_old) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-cache request FSM with optional LL/SC support.
// LL/SC is built only when MEM_STAGE_LLSC_EN is defined.
module mem_stage
  import cpu_types_pkg::*;
  import data_path_muxs_pkg::*;
(
  input  logic  CLK,
  input  logic  RST,
  input  logic  dREN_EX_MEM,
  input  logic  dWEN_EX_MEM,
  input  logic  datomic_EX_MEM,
  input  word_t dmemaddr_EX_MEM,
  input  word_t dmemstore_EX_MEM,
  input  logic  halt_EX_MEM,
  input  logic  dhit,
  input  word_t dmemload,
  input  logic  snoop_inv,
  input  word_t snoop_addr,
  output logic  dREN,
  output logic  dWEN,
  output word_t daddr,
  output word_t dstore,
  output word_t dload_MEM,
  output word_t sc_result,
  output logic  mem_stall,
  output logic  mem_done
);
  mem_stage_state_t state, state_nxt;
  logic access;
  logic hit_req;
  logic is_sc;
  logic link_match;
  logic sc_fail;

  assign access  = (dREN_EX_MEM | dWEN_EX_MEM) & ~halt_EX_MEM;
  assign hit_req = (state == REQ) & dhit;

`ifdef MEM_STAGE_LLSC_EN
  logic        is_ll;
  logic        link_set;
  logic        link_clr;
  logic        link_valid;
  logic [29:0] link_addr;
  logic        unused_snoop_lsb;

  assign unused_snoop_lsb = ^snoop_addr[1:0];
  assign is_ll      = dREN_EX_MEM & datomic_EX_MEM;
  assign is_sc      = dWEN_EX_MEM & datomic_EX_MEM;
  assign link_match = link_valid & word_match(dmemaddr_EX_MEM[31:2], link_addr);
  assign link_set   = hit_req & is_ll;
  // A successful SC consumes the link; a plain store to the linked word breaks it.
  assign link_clr   = hit_req & dWEN_EX_MEM & (is_sc | link_match);

  mem_link_reg u_link (
    .clk        (CLK),
    .rst        (RST),
    .set        (link_set),
    .set_addr   (dmemaddr_EX_MEM[31:2]),
    .clr        (link_clr),
    .snoop_inv  (snoop_inv),
    .snoop_addr (snoop_addr[31:2]),
    .valid      (link_valid),
    .addr       (link_addr)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      sc_result <= '0;
    end else if ((state == IDLE) && access && sc_fail) begin
      sc_result <= '0;
    end else if (hit_req && is_sc) begin
      sc_result <= word_t'(1);
    end
  end
`else
  logic unused_llsc;

  assign unused_llsc = ^{datomic_EX_MEM, snoop_inv, snoop_addr};
  assign is_sc       = 1'b0;
  assign link_match  = 1'b0;
  assign sc_result   = '0;
`endif

  // An SC without a live link completes without touching the cache.
  assign sc_fail = is_sc & ~link_match;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dREN      = 1'b0;
    dWEN      = 1'b0;
    mem_stall = 1'b0;
    mem_done  = 1'b0;
    if (!RST) begin
      unique case (state)
        IDLE: begin
          if (access) begin
            mem_stall = 1'b1;
            state_nxt = sc_fail ? DONE : REQ;
          end
        end
        REQ: begin
          dREN      = dREN_EX_MEM;
          dWEN      = dWEN_EX_MEM;
          mem_stall = 1'b1;
          if (dhit) state_nxt = DONE;
        end
        DONE: begin
          mem_done  = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign daddr  = dmemaddr_EX_MEM;
  assign dstore = dmemstore_EX_MEM;

  always_ff @(posedge CLK) begin
    if (RST) begin
      dload_MEM <= '0;
    end else if (hit_req && dREN_EX_MEM) begin
      dload_MEM <= dmemload;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage; expectations follow the LL/SC build option (MEM_STAGE_LLSC_EN).
module tb_mem_stage;
  import cpu_types_pkg::*;

`ifdef MEM_STAGE_LLSC_EN
  localparam bit LLSC = 1'b1;
`else
  localparam bit LLSC = 1'b0;
`endif

  logic  CLK = 1'b0;
  logic  RST;
  logic  dREN_EX_MEM, dWEN_EX_MEM, datomic_EX_MEM, halt_EX_MEM;
  word_t dmemaddr_EX_MEM, dmemstore_EX_MEM;
  logic  dhit;
  word_t dmemload;
  logic  snoop_inv;
  word_t snoop_addr;
  logic  dREN, dWEN, mem_stall, mem_done;
  word_t daddr, dstore, dload_MEM, sc_result;

  int n_chk = 0;
  int n_bad = 0;

  mem_stage dut (
    .CLK              (CLK),
    .RST              (RST),
    .dREN_EX_MEM      (dREN_EX_MEM),
    .dWEN_EX_MEM      (dWEN_EX_MEM),
    .datomic_EX_MEM   (datomic_EX_MEM),
    .dmemaddr_EX_MEM  (dmemaddr_EX_MEM),
    .dmemstore_EX_MEM (dmemstore_EX_MEM),
    .halt_EX_MEM      (halt_EX_MEM),
    .dhit             (dhit),
    .dmemload         (dmemload),
    .snoop_inv        (snoop_inv),
    .snoop_addr       (snoop_addr),
    .dREN             (dREN),
    .dWEN             (dWEN),
    .daddr            (daddr),
    .dstore           (dstore),
    .dload_MEM        (dload_MEM),
    .sc_result        (sc_result),
    .mem_stall        (mem_stall),
    .mem_done         (mem_done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Presents one EX/MEM access, answers with dhit after 'waits' request cycles,
  // and returns per-access cycle counts plus the first request seen.
  task automatic run_access(input logic ren, input logic wen, input logic atom,
                            input word_t addr, input word_t data, input int waits,
                            input word_t load, input logic snp,
                            output int stall_c, output int ren_c, output int wen_c,
                            output word_t req_addr, output word_t req_data);
    int   req_c;
    logic done;
    req_c = 0; done = 1'b0;
    stall_c = 0; ren_c = 0; wen_c = 0; req_addr = '0; req_data = '0;
    dREN_EX_MEM = ren; dWEN_EX_MEM = wen; datomic_EX_MEM = atom;
    dmemaddr_EX_MEM = addr; dmemstore_EX_MEM = data;
    for (int cyc = 0; cyc < 20 && !done; cyc++) begin
      dhit = 1'b0; snoop_inv = 1'b0;
      #1;
      if (mem_done) begin
        done = 1'b1;
        chk("done_stall", {31'd0, mem_stall}, 32'd0);
        chk("done_noreq", {30'd0, dREN, dWEN}, 32'd0);
      end else begin
        stall_c += int'(mem_stall);
        ren_c   += int'(dREN);
        wen_c   += int'(dWEN);
        if (dREN | dWEN) begin
          if (req_c == 0) begin
            req_addr = daddr;
            req_data = dstore;
          end
          if (req_c == waits) begin
            dhit = 1'b1; dmemload = load;
            snoop_inv = snp; snoop_addr = addr;
          end
          req_c++;
        end
        tick();
      end
    end
    dhit = 1'b0; snoop_inv = 1'b0;
    dREN_EX_MEM = 1'b0; dWEN_EX_MEM = 1'b0; datomic_EX_MEM = 1'b0;
    chk("done_seen", {31'd0, done}, 32'd1);
    tick();
  endtask

  int    s, r, w;
  word_t ra, rd;

  initial begin
    RST = 1'b1;
    dREN_EX_MEM = 1'b0; dWEN_EX_MEM = 1'b0; datomic_EX_MEM = 1'b0; halt_EX_MEM = 1'b0;
    dmemaddr_EX_MEM = '0; dmemstore_EX_MEM = '0; dhit = 1'b0; dmemload = '0;
    snoop_inv = 1'b0; snoop_addr = '0;
    tick(); tick();
    RST = 1'b0;
    #1;
    chk("rst_dren", {31'd0, dREN}, 32'd0);
    chk("rst_dwen", {31'd0, dWEN}, 32'd0);
    chk("rst_stall", {31'd0, mem_stall}, 32'd0);
    chk("rst_done", {31'd0, mem_done}, 32'd0);
    chk("rst_dload", dload_MEM, 32'd0);
    chk("rst_sc", sc_result, 32'd0);
`ifdef MEM_STAGE_LLSC_EN
    chk("rst_link", {31'd0, dut.link_valid}, 32'd0);
`endif

    // LW 0x100 with two wait cycles
    run_access(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 2, 32'hDEADBEEF, 1'b0, s, r, w, ra, rd);
    chk("lw_stall", s, 32'd4);
    chk("lw_ren", r, 32'd3);
    chk("lw_wen", w, 32'd0);
    chk("lw_addr", ra, 32'h100);
    chk("lw_data", dload_MEM, 32'hDEADBEEF);

    // SW 0x200, immediate hit
    run_access(1'b0, 1'b1, 1'b0, 32'h200, 32'h12345678, 0, 32'h0, 1'b0, s, r, w, ra, rd);
    chk("sw_wen", w, 32'd1);
    chk("sw_ren", r, 32'd0);
    chk("sw_stall", s, 32'd2);
    chk("sw_addr", ra, 32'h200);
    chk("sw_data", rd, 32'h12345678);
    chk("sw_keep_load", dload_MEM, 32'hDEADBEEF);

    // LL 0x300 then SC 0x300
    run_access(1'b1, 1'b0, 1'b1, 32'h300, 32'h0, 0, 32'hCAFE0001, 1'b0, s, r, w, ra, rd);
    chk("ll_ren", r, 32'd1);
    chk("ll_data", dload_MEM, 32'hCAFE0001);
`ifdef MEM_STAGE_LLSC_EN
    chk("ll_link_set", {31'd0, dut.link_valid}, 32'd1);
`endif
    run_access(1'b0, 1'b1, 1'b1, 32'h300, 32'h77, 0, 32'h0, 1'b0, s, r, w, ra, rd);
    chk("sc_ok_wen", w, 32'd1);
    chk("sc_ok_addr", ra, 32'h300);
    chk("sc_ok_result", sc_result, LLSC ? 32'd1 : 32'd0);
`ifdef MEM_STAGE_LLSC_EN
    chk("sc_ok_link_clr", {31'd0, dut.link_valid}, 32'd0);
`endif

    // sc_result holds across an ordinary load
    run_access(1'b1, 1'b0, 1'b0, 32'h104, 32'h0, 1, 32'h11, 1'b0, s, r, w, ra, rd);
    chk("sc_hold", sc_result, LLSC ? 32'd1 : 32'd0);
    chk("lw2_stall", s, 32'd3);

    // LL 0x300, snoop 0x302 (same word), SC 0x300 fails
    run_access(1'b1, 1'b0, 1'b1, 32'h300, 32'h0, 0, 32'h22, 1'b0, s, r, w, ra, rd);
    snoop_inv = 1'b1; snoop_addr = 32'h302;
    tick();
    snoop_inv = 1'b0;
`ifdef MEM_STAGE_LLSC_EN
    chk("snoop_link_clr", {31'd0, dut.link_valid}, 32'd0);
`endif
    run_access(1'b0, 1'b1, 1'b1, 32'h300, 32'h99, 0, 32'h0, 1'b0, s, r, w, ra, rd);
    chk("sc_fail_wen", w, LLSC ? 32'd0 : 32'd1);
    chk("sc_fail_stall", s, LLSC ? 32'd1 : 32'd2);
    chk("sc_fail_result", sc_result, 32'd0);

    // LL 0x400 broken by a plain store to 0x400
    run_access(1'b1, 1'b0, 1'b1, 32'h400, 32'h0, 0, 32'h33, 1'b0, s, r, w, ra, rd);
`ifdef MEM_STAGE_LLSC_EN
    chk("ll400_set", {31'd0, dut.link_valid}, 32'd1);
`endif
    run_access(1'b0, 1'b1, 1'b0, 32'h400, 32'h44, 0, 32'h0, 1'b0, s, r, w, ra, rd);
    chk("st400_wen", w, 32'd1);
`ifdef MEM_STAGE_LLSC_EN
    chk("st400_link_clr", {31'd0, dut.link_valid}, 32'd0);
`endif

    // LL 0x500 with a same-edge snoop to 0x500: clear wins
    run_access(1'b1, 1'b0, 1'b1, 32'h500, 32'h0, 0, 32'h55, 1'b1, s, r, w, ra, rd);
    chk("ll500_data", dload_MEM, 32'h55);
`ifdef MEM_STAGE_LLSC_EN
    chk("ll_snoop_race", {31'd0, dut.link_valid}, 32'd0);
`endif

    // halt blocks the request
    dREN_EX_MEM = 1'b1; halt_EX_MEM = 1'b1; dmemaddr_EX_MEM = 32'h700;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("halt_stall", {31'd0, mem_stall}, 32'd0);
      chk("halt_req", {30'd0, dREN, dWEN}, 32'd0);
      chk("halt_done", {31'd0, mem_done}, 32'd0);
      tick();
    end
    dREN_EX_MEM = 1'b0; halt_EX_MEM = 1'b0;
    tick();

    // reset while a load waits in REQ
    dREN_EX_MEM = 1'b1; dmemaddr_EX_MEM = 32'h600;
    #1;
    chk("rreq_idle_stall", {31'd0, mem_stall}, 32'd1);
    tick();
    chk("rreq_in_req", {31'd0, dREN}, 32'd1);
    RST = 1'b1;
    tick();
    chk("rreq_dren", {31'd0, dREN}, 32'd0);
    chk("rreq_stall", {31'd0, mem_stall}, 32'd0);
    chk("rreq_done", {31'd0, mem_done}, 32'd0);
    chk("rreq_dload", dload_MEM, 32'd0);
    RST = 1'b0; dREN_EX_MEM = 1'b0;
    tick();
    chk("post_rst_stall", {31'd0, mem_stall}, 32'd0);
    chk("post_rst_dren", {31'd0, dREN}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
